mix_columns_engine: RTL

Parametrised, handshaked AES MixColumns engine that performs forward (encrypt) or inverse (decrypt) MixColumns on a 128-bit state. It processes LANES columns per clock, so one datapath serves area-optimised (1 column/cycle) and throughput-optimised (4 columns/cycle) builds. It sits between the ShiftRows/InvShiftRows and AddRoundKey stages of the round datapath. It has a per-transfer bypass for the final round, which has no MixColumns.

---
 rtl/aes_gf_pkg.sv | 26 ++
 rtl/mix_column_unit.sv | 19 +
 rtl/mix_columns_engine.sv | 82 ++++++++
 3 files changed

// File: rtl/aes_gf_pkg.sv
// aes_gf_pkg: GF(2^8) helpers and FSM state type for the MixColumns engine
package aes_gf_pkg;
  localparam logic [7:0] AES_POLY = 8'h1b;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction
  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction
  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction
  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction
  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction
  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction
endpackage

// File: rtl/mix_column_unit.sv
// mix_column_unit: combinational forward/inverse MixColumns on one 32-bit column
module mix_column_unit
  import aes_gf_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic        i_inv,
  output logic [31:0] o_col
);
  logic [7:0] w_a   [4];
  logic [7:0] w_fwd [4];
  logic [7:0] w_inv [4];
  // each output row is the circulant matrix row applied to the rotated column
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign w_a[r]   = i_col[31-8*r -: 8];
    assign w_fwd[r] = gf_mul2(w_a[r]) ^ gf_mul3(w_a[(r+1)%4]) ^ w_a[(r+2)%4] ^ w_a[(r+3)%4];
    assign w_inv[r] = gf_mule(w_a[r]) ^ gf_mulb(w_a[(r+1)%4]) ^ gf_muld(w_a[(r+2)%4]) ^ gf_mul9(w_a[(r+3)%4]);
    assign o_col[31-8*r -: 8] = i_inv ? w_inv[r] : w_fwd[r];
  end
endmodule

// File: rtl/mix_columns_engine.sv
// mix_columns_engine: handshaked AES (Inv)MixColumns, LANES columns per cycle
module mix_columns_engine
  import aes_gf_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  input  logic         in_skip,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("mix_columns_engine: LANES must be 1, 2 or 4");
  end
  state_t       r_state, w_state_nxt;
  logic [127:0] r_w, w_w_nxt, w_busy_w;
  logic [1:0]   r_col, w_col_nxt;
  logic         r_inv, w_inv_nxt;
  logic         w_accept, w_last;
  logic [1:0]   w_idx      [LANES];
  logic [31:0]  w_lane_in  [LANES];
  logic [31:0]  w_lane_out [LANES];
  // column c lives at bits 127-32c, i.e. top index {~c, 5'h1f}
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_idx[k]     = r_col + 2'(k);
    assign w_lane_in[k] = r_w[{~w_idx[k], 5'h1f} -: 32];
    mix_column_unit u_mcu (
      .i_col (w_lane_in[k]),
      .i_inv (r_inv),
      .o_col (w_lane_out[k])
    );
  end
  assign w_last    = w_idx[LANES-1] == 2'd3;
  assign in_ready  = !rst && (r_state == IDLE || (r_state == DONE && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_state == DONE;
  assign out_data  = r_w;
  // splice the transformed lanes back into the working state
  always_comb begin
    w_busy_w = r_w;
    for (int j = 0; j < LANES; j++) w_busy_w[{~w_idx[j], 5'h1f} -: 32] = w_lane_out[j];
  end
  // next state: accept has priority so DONE can hand over directly to a new transfer
  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_col_nxt   = r_col;
    w_inv_nxt   = r_inv;
    if (w_accept) begin
      w_state_nxt = in_skip ? DONE : BUSY;
      w_w_nxt     = in_data;
      w_col_nxt   = '0;
      w_inv_nxt   = in_inv;
    end else if (r_state == BUSY) begin
      w_state_nxt = w_last ? DONE : BUSY;
      w_w_nxt     = w_busy_w;
      w_col_nxt   = r_col + 2'(LANES);
    end else if (r_state == DONE && out_ready) begin
      w_state_nxt = IDLE;
    end
  end
  // state, working register, column counter and latched mode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_w     <= '0;
      r_col   <= '0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_w     <= w_w_nxt;
      r_col   <= w_col_nxt;
      r_inv   <= w_inv_nxt;
    end
  end
endmodule
